// File: rtl/dunit_imem_loader.sv
// dunit_imem_loader: debug-unit controller in front of the IF stage.
// Takes bytes from the UART receiver and packs them into little-endian
// 32-bit words, which it writes into instruction memory. It also starts
// the pipeline in free-run or single-step mode through the clock enable.
// Optional feature macro: DUNIT_CYCLE_CNT_EN adds a saturating counter of
// clock-enabled cycles on o_cycle_count. Without it, the output is tied to 0.
//
// Handshake: a byte transfers on a rising edge where i_rx_valid and
// o_rx_ready are both high. o_rx_ready is registered. It is high in IDLE,
// LOAD and DONE, and it is low while this block is in reset.
module dunit_imem_loader #(
    parameter int                NB_REG    = 32,
    parameter int                NB_WIDHT  = 9,
    parameter int                NB_BYTE   = 8,
    parameter logic [NB_REG-1:0] HALT_INST = 32'hFFFFFFFF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_rx_valid,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    output logic                o_rx_ready,
    input  logic                i_halt_seen,
    output logic                o_dunit_clk_en,
    output logic                o_dunit_w_en,
    output logic [NB_WIDHT-1:0] o_dunit_addr,
    output logic [NB_REG-1:0]   o_dunit_data,
    output logic                o_loaded,
    output logic                o_load_err,
    output logic                o_halted,
    output logic [31:0]         o_cycle_count
);

    localparam int NB_CNT = $clog2(NB_REG / NB_BYTE);
    localparam logic [NB_CNT-1:0]   CNT_LAST  = NB_CNT'(NB_REG / NB_BYTE - 1);
    localparam logic [NB_WIDHT-1:0] ADDR_LAST = ~NB_WIDHT'(3);
    localparam logic [NB_BYTE-1:0]  CMD_LOAD  = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0]  CMD_RUN   = NB_BYTE'(8'h52);
    localparam logic [NB_BYTE-1:0]  CMD_STEP  = NB_BYTE'(8'h53);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RUN   = 3'd3,
        ST_STEP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [NB_WIDHT-1:0] addr_q, addr_d;
    logic [NB_CNT-1:0]   cnt_q, cnt_d;
    logic [NB_REG-1:0]   word_q, word_d;
    logic [NB_WIDHT-1:0] waddr_q, waddr_d;
    logic [NB_REG-1:0]   wdata_q, wdata_d;
    logic                loaded_q, loaded_d;
    logic                err_q, err_d;
    logic                halted_q, halted_d;
    logic                rx_ready_q, rx_ready_d;
    logic                accept;

    assign accept = i_rx_valid & rx_ready_q;

    // State and datapath registers; reset discards any partially built word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            loaded_q   <= 1'b0;
            err_q      <= 1'b0;
            halted_q   <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            loaded_q   <= loaded_d;
            err_q      <= err_d;
            halted_q   <= halted_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    // Next-state logic: command decode, byte packing, write sequencing and run control.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        loaded_d = loaded_q;
        err_d    = err_q;
        halted_d = halted_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (i_rx_data == CMD_LOAD) begin
                        state_d  = ST_LOAD;
                        addr_d   = '0;
                        cnt_d    = '0;
                        loaded_d = 1'b0;
                        err_d    = 1'b0;
                        halted_d = 1'b0;
                    end else if (i_rx_data == CMD_RUN && state_q == ST_IDLE) begin
                        state_d = ST_RUN;
                    end else if (i_rx_data == CMD_STEP && state_q == ST_IDLE) begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    // Shift in from the top so the first byte ends up in bits [7:0].
                    word_d = {i_rx_data, word_q[NB_REG-1:NB_BYTE]};
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        waddr_d = addr_q;
                        wdata_d = word_d;
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d = cnt_q + NB_CNT'(1);
                    end
                end
            end
            ST_WRITE: begin
                if (wdata_q == HALT_INST) begin
                    loaded_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (addr_q == ADDR_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    addr_d  = addr_q + NB_WIDHT'(4);
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (i_halt_seen) begin
                    halted_d = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_STEP: begin
                if (i_halt_seen) begin
                    halted_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_DONE);
    end

    assign o_rx_ready     = rx_ready_q;
    assign o_dunit_clk_en = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign o_dunit_w_en   = (state_q == ST_WRITE);
    assign o_dunit_addr   = waddr_q;
    assign o_dunit_data   = wdata_q;
    assign o_loaded       = loaded_q;
    assign o_load_err     = err_q;
    assign o_halted       = halted_q;

`ifdef DUNIT_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;
    logic        cmd_load;

    assign cmd_load = accept && (i_rx_data == CMD_LOAD) &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Saturating count of clock-enabled cycles; a new load starts it from zero.
    always_comb begin
        cyc_d = cyc_q;
        if (cmd_load) begin
            cyc_d = '0;
        end else if (o_dunit_clk_en && (cyc_q != 32'hFFFFFFFF)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign o_cycle_count = cyc_q;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_dunit_imem_loader.sv
// Directed bench for dunit_imem_loader: reset, load, run, step, back-pressure,
// memory overflow and reset during a load.
module tb_dunit_imem_loader;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        halt_seen;
    logic        clk_en;
    logic        w_en;
    logic [8:0]  waddr;
    logic [31:0] wdata;
    logic        loaded;
    logic        load_err;
    logic        halted;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    logic [8:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [8:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];

`ifdef DUNIT_CYCLE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    dunit_imem_loader dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_rx_valid     (rx_valid),
        .i_rx_data      (rx_data),
        .o_rx_ready     (rx_ready),
        .i_halt_seen    (halt_seen),
        .o_dunit_clk_en (clk_en),
        .o_dunit_w_en   (w_en),
        .o_dunit_addr   (waddr),
        .o_dunit_data   (wdata),
        .o_loaded       (loaded),
        .o_load_err     (load_err),
        .o_halted       (halted),
        .o_cycle_count  (cycle_count)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Capture write pulses; a write must never overlap a clock-enabled cycle.
    always @(negedge clk) begin
        if (w_en === 1'b1) begin
            wr_addr_q.push_back(waddr);
            wr_data_q.push_back(wdata);
            checks++;
            if (clk_en !== 1'b0) begin
                errors++;
                $display("FAIL w_en_vs_clk_en: clk_en=%b during write, required 0", clk_en);
            end
        end
    end

    // Present a byte and hold it until it transfers; valid stays high afterwards.
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        @(negedge clk);
        while (rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h not accepted, rx_ready=%b required 1", b, rx_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_rx();
        rx_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic do_reset();
        idle_rx();
        halt_seen = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({clk_en, w_en, loaded, load_err, halted, rx_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000", {clk_en, w_en, loaded, load_err, halted, rx_ready});
        end
        checks++;
        if (waddr !== 9'h0 || wdata !== 32'h0 || cycle_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h data=%h cnt=%0d required 0", waddr, wdata, cycle_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: rx_ready=%b required 1", rx_ready);
        end
    endtask

    task automatic test_load();
        logic [7:0] prog [9] = '{8'h4C, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_addr_q = '{9'h000, 9'h004};
        exp_data_q = '{32'h44332211, 32'hFFFFFFFF};
        for (int i = 0; i < 9; i++) begin
            send_byte(prog[i]);
            idle_rx();
        end
        wait_cycles(3);
        checks++;
        if (wr_addr_q.size() != exp_addr_q.size()) begin
            errors++;
            $display("FAIL load_count: %0d writes, required %0d", wr_addr_q.size(), exp_addr_q.size());
        end
        while (exp_addr_q.size() > 0 && wr_addr_q.size() > 0) begin
            logic [8:0]  ea;
            logic [8:0]  ga;
            logic [31:0] ed;
            logic [31:0] gd;
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            ga = wr_addr_q.pop_front();
            gd = wr_data_q.pop_front();
            checks++;
            if (ga !== ea || gd !== ed) begin
                errors++;
                $display("FAIL load_write: addr=%h data=%h, required addr=%h data=%h", ga, gd, ea, ed);
            end
        end
        checks++;
        if (loaded !== 1'b1 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL load_flags: loaded=%b err=%b, required 1 0", loaded, load_err);
        end
        checks++;
        if (waddr !== 9'h004 || wdata !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL load_hold: addr=%h data=%h, required 004 ffffffff", waddr, wdata);
        end
    endtask

    task automatic test_run();
        int en_cycles;
        en_cycles = 0;
        send_byte(8'h52);
        idle_rx();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (clk_en === 1'b1) en_cycles++;
            if (i == 5) halt_seen = 1'b1;
        end
        @(posedge clk);
        #1;
        halt_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (clk_en === 1'b1) en_cycles++;
        end
        checks++;
        if (en_cycles != 6) begin
            errors++;
            $display("FAIL run_cycles: clk_en high %0d cycles, required 6", en_cycles);
        end
        checks++;
        if (halted !== 1'b1 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL run_halted: halted=%b rx_ready=%b, required 1 1", halted, rx_ready);
        end
        checks++;
        if (cycle_count !== (CNT_ON ? 32'd6 : 32'd0)) begin
            errors++;
            $display("FAIL run_count: cycle_count=%0d required %0d", cycle_count, CNT_ON ? 6 : 0);
        end
    endtask

    task automatic test_step();
        int en_cycles;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            en_cycles = 0;
            send_byte(8'h53);
            idle_rx();
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (clk_en === 1'b1) en_cycles++;
            end
            checks++;
            if (en_cycles != 1 || rx_ready !== 1'b1 || halted !== 1'b0) begin
                errors++;
                $display("FAIL step_%0d: en_cycles=%0d rx_ready=%b halted=%b, required 1 1 0", s, en_cycles, rx_ready, halted);
            end
        end
        checks++;
        if (cycle_count !== (CNT_ON ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL step_count: cycle_count=%0d required %0d", cycle_count, CNT_ON ? 3 : 0);
        end
        send_byte(8'h53);
        idle_rx();
        halt_seen = 1'b1;
        @(posedge clk);
        #1;
        halt_seen = 1'b0;
        wait_cycles(2);
        checks++;
        if (halted !== 1'b1 || clk_en !== 1'b0) begin
            errors++;
            $display("FAIL step_halt: halted=%b clk_en=%b, required 1 0", halted, clk_en);
        end
        send_byte(8'h53);
        idle_rx();
        checks++;
        if (clk_en !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL done_ignores_s: clk_en=%b halted=%b, required 0 1", clk_en, halted);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] prog [13] = '{8'h4C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                  8'hFF, 8'hFF, 8'hFF, 8'hFF};
        int ready_hi;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            send_byte(prog[i]);
            if (i == 4) begin
                checks++;
                if (rx_ready !== 1'b0 || w_en !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_write: rx_ready=%b w_en=%b, required 0 1", rx_ready, w_en);
                end
            end
        end
        idle_rx();
        wait_cycles(3);
        checks++;
        if (wr_data_q.size() != 3 || wr_data_q[0] !== 32'h04030201 || wr_data_q[1] !== 32'h08070605) begin
            errors++;
            $display("FAIL bp_words: n=%0d w0=%h w1=%h, required 3 04030201 08070605",
                     wr_data_q.size(), wr_data_q.size() > 0 ? wr_data_q[0] : 32'h0,
                     wr_data_q.size() > 1 ? wr_data_q[1] : 32'h0);
        end
        send_byte(8'h52);
        rx_data = 8'h4C;
        ready_hi = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rx_ready === 1'b1) ready_hi++;
        end
        checks++;
        if (ready_hi != 0 || loaded !== 1'b1) begin
            errors++;
            $display("FAIL bp_run: ready cycles=%0d loaded=%b, required 0 1", ready_hi, loaded);
        end
        halt_seen = 1'b1;
        @(posedge clk);
        #1;
        halt_seen = 1'b0;
        @(posedge clk);
        #1;
        idle_rx();
        checks++;
        if (loaded !== 1'b0 || halted !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: loaded=%b halted=%b rx_ready=%b, required 0 0 1", loaded, halted, rx_ready);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        do_reset();
        send_byte(8'h4C);
        for (int w = 0; w < 128; w++) begin
            b = 8'(w);
            send_byte(b);
            send_byte(8'h01);
            send_byte(8'h02);
            send_byte(8'h03);
        end
        idle_rx();
        wait_cycles(3);
        checks++;
        if (wr_addr_q.size() != 128) begin
            errors++;
            $display("FAIL ovf_count: %0d writes, required 128", wr_addr_q.size());
        end
        checks++;
        if (wr_addr_q.size() == 128 && (wr_addr_q[0] !== 9'h000 || wr_addr_q[127] !== 9'h1FC ||
                                        wr_data_q[127] !== 32'h0302017F)) begin
            errors++;
            $display("FAIL ovf_last: first=%h last=%h data=%h, required 000 1fc 0302017f",
                     wr_addr_q[0], wr_addr_q[127], wr_data_q[127]);
        end
        checks++;
        if (load_err !== 1'b1 || loaded !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flags: err=%b loaded=%b, required 1 0", load_err, loaded);
        end
        send_byte(8'h52);
        idle_rx();
        checks++;
        if (clk_en !== 1'b1) begin
            errors++;
            $display("FAIL ovf_cmd: clk_en=%b after R, required 1", clk_en);
        end
        halt_seen = 1'b1;
        @(posedge clk);
        #1;
        halt_seen = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        send_byte(8'h4C);
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle_rx();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({rx_ready, clk_en, w_en, loaded, load_err, halted} !== 6'b0 || waddr !== 9'h0 || wdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_async: flags=%b addr=%h data=%h, required all 0",
                     {rx_ready, clk_en, w_en, loaded, load_err, halted}, waddr, wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: rx_ready=%b required 1", rx_ready);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        idle_rx();
        wait_cycles(3);
        checks++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 9'h000 || wr_data_q[0] !== 32'h04030201) begin
            errors++;
            $display("FAIL midreset_word: n=%0d addr=%h data=%h, required 1 000 04030201",
                     wr_addr_q.size(), wr_addr_q.size() > 0 ? wr_addr_q[0] : 9'h0,
                     wr_data_q.size() > 0 ? wr_data_q[0] : 32'h0);
        end
    endtask

    // Test sequence and final report.
    initial begin
        rst       = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        halt_seen = 1'b0;
        test_reset();
        test_load();
        test_run();
        test_step();
        test_back_to_back();
        test_overflow();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
